// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, Nk/Nr lookup,
// round constants and the forward S-box.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128  = 2'b00,
        KL_192  = 2'b01,
        KL_256  = 2'b10,
        KL_RSVD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DRAIN
    } ks_state_e;

    localparam int WIN_WORDS = 8;

    // Byte 0x00 maps to the most significant byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Key sizes the instance cannot hold fall back to AES-128.
    function automatic key_len_e decode_key_len(input logic [1:0] kl, input int nr_max);
        case (kl)
            2'b01:   return (nr_max >= 12) ? KL_192 : KL_128;
            2'b10:   return (nr_max >= 14) ? KL_256 : KL_128;
            default: return KL_128;
        endcase
    endfunction

    function automatic logic [3:0] nk_of(input key_len_e kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel forward S-boxes applied to one 32-bit word (combinational).
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign sub_word[8*gi +: 8] = sbox(word[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES key expansion: one word per cycle through an 8-word sliding
// window, round keys streamed out with valid/ready. AES_KS_KEYSTORE_EN adds a readable round-key store.
module aes_key_sched_iter
    import aes_pkg::*;
#(
    parameter int NR_MAX = 14,
    parameter int KEY_W  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic [1:0]       key_len,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             rk_last,
    output logic             busy
`ifdef AES_KS_KEYSTORE_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [127:0]     rd_key,
    output logic             rd_ok
`endif
);

    ks_state_e    state_reg;
    logic [31:0]  win_reg [0:WIN_WORDS-1];
    logic [5:0]   i_reg;
    logic [3:0]   phase_reg;
    logic [3:0]   rcon_idx_reg;
    logic [4:0]   emit_reg;
    logic [3:0]   nk_reg;
    logic [3:0]   nr_reg;
    logic [127:0] rk_data_reg;
    logic [3:0]   rk_idx_reg;
    logic         rk_valid_reg;
    logic         rk_last_reg;
    logic         key_ready_reg;
    logic         busy_reg;

    logic [31:0]  key_word [0:WIN_WORDS-1];
    key_len_e     kl_dec;
    logic [3:0]   nk_next;
    logic [3:0]   nr_next;
    logic         accept;
    logic [5:0]   last_word_idx;
    logic [6:0]   beat_base;
    logic         compute_en;
    logic         beat_avail;
    logic         load_beat;
    logic         beat_taken;
    logic [31:0]  prev_word;
    logic [31:0]  back_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp_word;
    logic [31:0]  new_word;
    logic [127:0] beat_data;

    for (genvar gi = 0; gi < WIN_WORDS; gi++) begin : g_key_word
        if (gi < KEY_W / 32) begin : g_present
            assign key_word[gi] = key_in[KEY_W-1-32*gi -: 32];
        end else begin : g_absent
            assign key_word[gi] = 32'h0;
        end
    end

    assign kl_dec        = decode_key_len(key_len, NR_MAX);
    assign nk_next       = nk_of(kl_dec);
    assign nr_next       = nr_of(kl_dec);
    assign accept        = key_valid && key_ready_reg;
    assign last_word_idx = {nr_reg, 2'b11};
    assign beat_base     = {emit_reg, 2'b00};

    // Word i lives in slot i mod 8, so w[i-1] and w[i-Nk] are always resident.
    assign prev_word = win_reg[i_reg[2:0] - 3'd1];
    assign back_word = win_reg[i_reg[2:0] - nk_reg[2:0]];
    assign sub_in    = (phase_reg == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sbox_word u_sbox (
        .word     (sub_in),
        .sub_word (sub_out)
    );

    always_comb begin
        temp_word = prev_word;
        if (phase_reg == 4'd0) begin
            temp_word = sub_out ^ {rcon(rcon_idx_reg), 24'h0};
        end else if (nk_reg == 4'd8 && phase_reg == 4'd4) begin
            temp_word = sub_out;
        end
    end

    assign new_word = back_word ^ temp_word;

    // Writing word i evicts word i-8; hold off while that word belongs to an unsent beat.
    assign compute_en = (state_reg == ST_EXPAND) && ({1'b0, i_reg} < beat_base + 7'd8);
    assign beat_avail = (state_reg != ST_IDLE) && (emit_reg <= {1'b0, nr_reg}) &&
                        ((beat_base + 7'd3 < {1'b0, i_reg}) ||
                         (compute_en && (beat_base + 7'd3 == {1'b0, i_reg})));
    assign beat_taken = rk_valid_reg && rk_ready;
    assign load_beat  = beat_avail && (!rk_valid_reg || rk_ready);

    // The word being computed this cycle is forwarded so a beat leaves right after its last word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_beat
        logic [6:0] idx;
        assign idx = beat_base + 7'(gi);
        assign beat_data[127-32*gi -: 32] =
            (compute_en && idx == {1'b0, i_reg}) ? new_word : win_reg[idx[2:0]];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < WIN_WORDS; j++) begin
                win_reg[j] <= key_word[j];
            end
        end else if (compute_en) begin
            win_reg[i_reg[2:0]] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            i_reg         <= 6'd0;
            phase_reg     <= 4'd0;
            rcon_idx_reg  <= 4'd0;
            emit_reg      <= 5'd0;
            nk_reg        <= 4'd4;
            nr_reg        <= 4'd10;
            rk_data_reg   <= 128'h0;
            rk_idx_reg    <= 4'd0;
            rk_valid_reg  <= 1'b0;
            rk_last_reg   <= 1'b0;
            key_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    key_ready_reg <= 1'b1;
                    if (accept) begin
                        state_reg     <= ST_EXPAND;
                        key_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        nk_reg        <= nk_next;
                        nr_reg        <= nr_next;
                        i_reg         <= {2'b00, nk_next};
                        phase_reg     <= 4'd0;
                        rcon_idx_reg  <= 4'd1;
                        emit_reg      <= 5'd1;
                        rk_data_reg   <= {key_word[0], key_word[1], key_word[2], key_word[3]};
                        rk_idx_reg    <= 4'd0;
                        rk_valid_reg  <= 1'b1;
                        rk_last_reg   <= 1'b0;
                    end
                end
                default: begin
                    if (compute_en) begin
                        i_reg <= i_reg + 6'd1;
                        if (phase_reg == nk_reg - 4'd1) begin
                            phase_reg    <= 4'd0;
                            rcon_idx_reg <= rcon_idx_reg + 4'd1;
                        end else begin
                            phase_reg <= phase_reg + 4'd1;
                        end
                        if (i_reg == last_word_idx) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                    if (load_beat) begin
                        rk_data_reg  <= beat_data;
                        rk_idx_reg   <= emit_reg[3:0];
                        rk_last_reg  <= (emit_reg == {1'b0, nr_reg});
                        rk_valid_reg <= 1'b1;
                        emit_reg     <= emit_reg + 5'd1;
                    end else if (beat_taken) begin
                        rk_valid_reg <= 1'b0;
                        rk_last_reg  <= 1'b0;
                        if (rk_last_reg) begin
                            state_reg     <= ST_IDLE;
                            busy_reg      <= 1'b0;
                            key_ready_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign key_ready = key_ready_reg;
    assign rk_data   = rk_data_reg;
    assign rk_idx    = rk_idx_reg;
    assign rk_valid  = rk_valid_reg;
    assign rk_last   = rk_last_reg;
    assign busy      = busy_reg;

`ifdef AES_KS_KEYSTORE_EN
    logic [127:0]  store_mem [0:NR_MAX];
    logic [127:0]  rd_key_reg;
    logic [NR_MAX:0] written_reg;
    logic          rd_ok_reg;

    always_ff @(posedge clk) begin
        if (beat_taken) begin
            store_mem[rk_idx_reg] <= rk_data_reg;
        end
        rd_key_reg <= store_mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_reg <= '0;
            rd_ok_reg   <= 1'b0;
        end else if (accept) begin
            written_reg <= '0;
            rd_ok_reg   <= 1'b0;
        end else begin
            if (beat_taken) begin
                written_reg[rk_idx_reg] <= 1'b1;
            end
            rd_ok_reg <= (int'(rd_idx) <= NR_MAX) && written_reg[rd_idx];
        end
    end

    assign rd_key = rd_key_reg;
    assign rd_ok  = rd_ok_reg;
`endif

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Self-checking bench for aes_key_sched_iter: FIPS-197 vectors, random keys,
// random back-pressure and a mid-run reset against a GF(2^8)-derived model.
module tb_aes_key_sched_iter;

    logic         clk;
    logic         rst_n;
    logic [255:0] key_in;
    logic [1:0]   key_len;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
`ifdef AES_KS_KEYSTORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_ok;
`endif

    int n_assert;
    int n_fail;

    logic [7:0]   sb [0:255];
    logic [127:0] ref_rk [0:14];
    logic [255:0] k128, k192, k256, krnd;
    logic [127:0] lb;

    aes_key_sched_iter #(.NR_MAX(14), .KEY_W(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_len   (key_len),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last),
        .busy      (busy)
`ifdef AES_KS_KEYSTORE_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .rd_ok     (rd_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int n = 0; n < 254; n++) inv = gmul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
            {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic void build_ref(input logic [255:0] key, input logic [1:0] kl);
        int nk, nr;
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Loads one key and consumes its beats; abort_at >= 0 pulses reset when that beat shows.
    task automatic run_key(input logic [255:0] key, input logic [1:0] kl, input int duty,
                           input bit hold_valid, input int abort_at, output logic [127:0] last_beat);
        int nr, k, cyc;
        nr = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
        build_ref(key, kl);
        last_beat = '0;
        cyc = 0;
        while (!key_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("key_ready_idle", 128'(key_ready), 128'(1));
        key_in    = key;
        key_len   = kl;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = hold_valid;
        key_in    = rand_key();
        check("busy_after_accept", 128'(busy), 128'(1));
        check("key_ready_after_accept", 128'(key_ready), 128'(0));
        check("beat0_latency", 128'(rk_valid), 128'(1));
        k = 0;
        cyc = 0;
        while (k <= nr && cyc < 3000) begin
            if (rk_valid) begin
                check($sformatf("rk_idx_k%0d", k), 128'(rk_idx), 128'(k));
                check($sformatf("rk_data_k%0d", k), rk_data, ref_rk[k]);
                check($sformatf("rk_last_k%0d", k), 128'(rk_last), 128'(k == nr));
                if (k == abort_at) begin
                    rst_n     = 1'b0;
                    key_valid = 1'b0;
                    rk_ready  = 1'b0;
                    #1;
                    check("rst_rk_valid", 128'(rk_valid), 128'(0));
                    check("rst_busy", 128'(busy), 128'(0));
                    check("rst_key_ready", 128'(key_ready), 128'(0));
                    check("rst_rk_data", rk_data, 128'h0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int n = 0; n < 6; n++) begin
                        @(negedge clk);
                        check("no_beat_after_reset", 128'(rk_valid), 128'(0));
                    end
                    check("key_ready_after_reset", 128'(key_ready), 128'(1));
                    return;
                end
                rk_ready = ($urandom_range(0, 99) < duty);
                if (rk_ready) begin
                    if (k == nr) last_beat = rk_data;
                    k++;
                end
            end else begin
                rk_ready = ($urandom_range(0, 99) < duty);
            end
            @(negedge clk);
            cyc++;
            if (hold_valid) key_in = rand_key();
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        check("beat_count", 128'(k), 128'(nr + 1));
        check("idle_after_last", 128'(key_ready), 128'(1));
        check("busy_after_last", 128'(busy), 128'(0));
        check("no_extra_beat", 128'(rk_valid), 128'(0));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        for (int b = 0; b < 256; b++) sb[b] = calc_sbox(8'(b));
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst_n     = 1'b0;
        key_in    = '0;
        key_len   = 2'b00;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
`ifdef AES_KS_KEYSTORE_EN
        rd_idx    = 4'd0;
`endif
        #1;
        check("reset_key_ready", 128'(key_ready), 128'(0));
        check("reset_rk_valid", 128'(rk_valid), 128'(0));
        check("reset_rk_last", 128'(rk_last), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_rk_idx", 128'(rk_idx), 128'(0));
        check("reset_rk_data", rk_data, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("key_ready_after_release", 128'(key_ready), 128'(1));

        run_key(k128, 2'b00, 100, 1'b0, -1, lb);
        check("aes128_beat10", lb, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(k192, 2'b01, 100, 1'b0, -1, lb);
        check("aes192_beat12", lb, 128'he98ba06f448c773c8ecc720401002202);
        run_key(k256, 2'b10, 100, 1'b0, -1, lb);
        check("aes256_beat14", lb, 128'hfe4890d1e6188d0b046df344706c631e);
        run_key(k256, 2'b10, 30, 1'b1, -1, lb);
        check("aes256_stall_beat14", lb, 128'hfe4890d1e6188d0b046df344706c631e);
        run_key(k128, 2'b00, 100, 1'b0, 5, lb);
        run_key(k192, 2'b01, 100, 1'b0, -1, lb);
        check("aes192_after_reset", lb, 128'he98ba06f448c773c8ecc720401002202);
        for (int r = 0; r < 4; r++) begin
            krnd = rand_key();
            run_key(krnd, 2'($urandom_range(0, 3)), int'($urandom_range(20, 100)),
                    1'($urandom_range(0, 1)), -1, lb);
        end
        run_key(k128, 2'b11, 60, 1'b0, -1, lb);
        check("reserved_len_beat10", lb, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key(k128, 2'b00, 100, 1'b0, -1, lb);
`ifdef AES_KS_KEYSTORE_EN
        rd_idx = 4'd10;
        @(negedge clk);
        check("store_rd_key10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("store_rd_ok10", 128'(rd_ok), 128'(1));
        rd_idx = 4'd0;
        @(negedge clk);
        check("store_rd_key0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_iter.md
AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

Interface
REQ-001 SHALL expose parameter NR_MAX, default 14: largest round count supported; legal values 10, 12, 14.
REQ-002 SHALL expose parameter KEY_W, default 256: width of key_in; equals 32*Nk(max).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port key_in, input, KEY_W: cipher key, left-aligned; word 0 is bits [KEY_W-1 -: 32].
REQ-006 SHALL have port key_len, input, 2: key size, 00=128, 01=192, 10=256, 11=reserved.
REQ-007 SHALL have port key_valid, input, 1: key_in and key_len valid.
REQ-008 SHALL have port key_ready, output, 1: block idle and able to accept a key.
REQ-009 SHALL have port rk_data, output, 128: round key, w[4k] in bits [127:96].
REQ-010 SHALL have port rk_idx, output, 4: round index k of rk_data.
REQ-011 SHALL have port rk_valid, output, 1: rk_data/rk_idx valid.
REQ-012 SHALL have port rk_ready, input, 1: consumer accepts the beat.
REQ-013 SHALL have port rk_last, output, 1: high with beat k = Nr.
REQ-014 SHALL have port busy, output, 1: expansion in progress.

Function
REQ-015 SHALL accept a key when key_valid && key_ready; key_ready is high only in IDLE.
REQ-016 SHALL use Nk/Nr = 4/10, 6/12, 8/14 for key_len 00/01/10; key_len=11 SHALL be treated as 00.
REQ-017 SHALL implement FSM IDLE -> EXPAND on accept; EXPAND -> DRAIN after word 4(Nr+1)-1 is computed; DRAIN -> IDLE when the rk_last beat is accepted.
REQ-018 SHALL compute one word per cycle in EXPAND per FIPS-197: i mod Nk==0 -> SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk]; Nk==8 && i mod 8==4 -> SubWord(w[i-1]); else w[i-1]; result XORed with w[i-Nk].
REQ-019 SHALL use Rcon sequence 01,02,04,08,10,20,40,80,1b,36 in the MSB byte.
REQ-020 SHALL hold the last Nk words in an 8-word sliding window register; no full key-schedule storage unless REQ-030 applies.
REQ-021 SHALL present beat k (words 4k..4k+3) with rk_valid asserted the cycle after word 4k+3 is registered; beat 0 is valid the cycle after accept.
REQ-022 SHALL keep rk_data, rk_idx and rk_last stable while rk_valid && !rk_ready.
REQ-023 SHALL stall word generation while a completed beat is pending and the next beat's words would overwrite needed window entries; no beat is dropped or duplicated.
REQ-024 SHALL emit beats k = 0..Nr in ascending order, exactly Nr+1 beats per key.
REQ-025 SHALL ignore key_valid while busy; key_in may change freely after acceptance.

Reset
REQ-026 SHALL, on rst_n low, immediately enter IDLE and set rk_valid=0, rk_last=0, busy=0, rk_idx=0, rk_data=0, key_ready=0 during reset, and key_ready=1 the first cycle after release.
REQ-027 SHALL abandon any expansion in progress on reset and emit no further beats of that key.

Configuration
REQ-028 SHALL support macro AES_KS_KEYSTORE_EN.
REQ-029 Without AES_KS_KEYSTORE_EN, there SHALL be no storage beyond the window and output register.
REQ-030 With AES_KS_KEYSTORE_EN, SHALL add a (NR_MAX+1)x128 store written at each accepted beat, plus ports rd_idx (in, 4), rd_key (out, 128), and rd_ok (out, 1). rd_key SHALL have 1-cycle latency. rd_ok SHALL be high once that index is written for the current key and SHALL be cleared on accept and on reset.

Structure
REQ-031 SHALL place the key_len encoding, Nk/Nr lookup, Rcon table and S-box function in shared package aes_pkg.
REQ-032 SHALL instantiate sub-module aes_sbox_word (4 parallel S-boxes, 32-bit combinational) exactly once.

Verification
REQ-033 With key_len=00, key 2b7e151628aed2a6abf7158809cf4f3c, and rk_ready=1, SHALL produce 11 beats, beat 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
REQ-034 With key_len=01, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, SHALL produce 13 beats, beat 12 = e98ba06f448c773c8ecc720401002202.
REQ-035 With key_len=10, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, SHALL produce 15 beats, beat 14 = fe4890d1e6188d0b046df344706c631e.
REQ-036 With the AES-256 case and rk_ready randomly toggled at 30% duty, SHALL produce identical beats in order with data stable during stalls.
REQ-037 With rst_n pulsed low at beat 5 of an AES-128 run, rk_valid SHALL drop asynchronously and a subsequent AES-192 key SHALL produce the correct 13 beats.
REQ-038 With AES_KS_KEYSTORE_EN, after the AES-128 run, rd_idx=10 SHALL give rd_key = d014f9a8c9ee2589e13f0cc8b6630ca6 next cycle with rd_ok=1.
